// File: rtl/conf_int_add__conf_ctrl.sv
// Precision-sweep controller for a configurable approximate adder: walks the
// configuration levels upward and keeps the highest one whose absolute error
// stays within err_thresh. Optional best_err output: CONF_CTRL_ERR_REPORT_EN.
module conf_int_add__conf_ctrl #(
    parameter int unsigned DATA_PATH_BITWIDTH = 16,
    parameter int unsigned CONF_SELECT__C_B   = 4,
    parameter int unsigned MAX_CONF           = 4,
    parameter int unsigned CONF_STEP          = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic [DATA_PATH_BITWIDTH-1:0] err_thresh,
    input  logic [DATA_PATH_BITWIDTH-1:0] approx_sum,
    output logic [DATA_PATH_BITWIDTH-1:0] op_a,
    output logic [DATA_PATH_BITWIDTH-1:0] op_b,
    output logic [CONF_SELECT__C_B-1:0]   conf_select,
    output logic                          busy,
    output logic                          done,
    output logic [CONF_SELECT__C_B-1:0]   best_conf,
    output logic                          fail
`ifdef CONF_CTRL_ERR_REPORT_EN
    ,
    output logic [DATA_PATH_BITWIDTH-1:0] best_err
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t                          state_q, state_d;
    logic [CONF_SELECT__C_B-1:0]     level_q, level_d;
    logic [CONF_SELECT__C_B-1:0]     best_conf_q, best_conf_d;
    logic                            fail_q, fail_d;
    logic [DATA_PATH_BITWIDTH-1:0]   op_a_q, op_a_d;
    logic [DATA_PATH_BITWIDTH-1:0]   op_b_q, op_b_d;
    logic [DATA_PATH_BITWIDTH-1:0]   exact_q, exact_d;
    logic [DATA_PATH_BITWIDTH-1:0]   thresh_q, thresh_d;
`ifdef CONF_CTRL_ERR_REPORT_EN
    logic [DATA_PATH_BITWIDTH-1:0]   best_err_q, best_err_d;
`endif

    int unsigned                     drop;
    logic [DATA_PATH_BITWIDTH-1:0]   keep_mask;
    logic [DATA_PATH_BITWIDTH-1:0]   masked;
    logic [DATA_PATH_BITWIDTH-1:0]   err;
    logic                            at_max;

    // Dropped low bits may be undefined in the adder; force them to zero
    // before measuring the error against the exact sum.
    always_comb begin
        drop      = CONF_STEP * 32'(level_q);
        keep_mask = '0;
        for (int unsigned i = 0; i < DATA_PATH_BITWIDTH; i++) begin
            keep_mask[i] = (i >= drop);
        end
        masked = approx_sum & keep_mask;
        err    = (exact_q >= masked) ? (exact_q - masked) : (masked - exact_q);
        at_max = (level_q == CONF_SELECT__C_B'(MAX_CONF));
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        best_conf_d = best_conf_q;
        fail_d      = fail_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        exact_d     = exact_q;
        thresh_d    = thresh_q;
`ifdef CONF_CTRL_ERR_REPORT_EN
        best_err_d  = best_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d   = a;
                    op_b_d   = b;
                    thresh_d = err_thresh;
                    exact_d  = a + b;
                    level_d  = '0;
                    fail_d   = 1'b0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: state_d = SAMPLE;
            SAMPLE: begin
                if (err <= thresh_q) begin
                    best_conf_d = level_q;
`ifdef CONF_CTRL_ERR_REPORT_EN
                    best_err_d  = err;
`endif
                    if (at_max) begin
                        state_d = DONE;
                    end else begin
                        level_d = level_q + 1'b1;
                        state_d = DRIVE;
                    end
                end else begin
                    if (level_q == '0) begin
                        fail_d      = 1'b1;
                        best_conf_d = '0;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            best_conf_q <= '0;
            fail_q      <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            exact_q     <= '0;
            thresh_q    <= '0;
`ifdef CONF_CTRL_ERR_REPORT_EN
            best_err_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            best_conf_q <= best_conf_d;
            fail_q      <= fail_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            exact_q     <= exact_d;
            thresh_q    <= thresh_d;
`ifdef CONF_CTRL_ERR_REPORT_EN
            best_err_q  <= best_err_d;
`endif
        end
    end

    // Outside a sweep the adder is left at the chosen precision.
    always_comb begin
        op_a        = op_a_q;
        op_b        = op_b_q;
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        best_conf   = best_conf_q;
        fail        = fail_q;
        conf_select = (state_q == DRIVE || state_q == SAMPLE) ? level_q : best_conf_q;
`ifdef CONF_CTRL_ERR_REPORT_EN
        best_err    = best_err_q;
`endif
    end

endmodule

// File: tb/tb_conf_int_add__conf_ctrl.sv
// Directed bench for conf_int_add__conf_ctrl with a bit-accurate adder model
// whose dropped low bits are filled with junk.
module tb_conf_int_add__conf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b, err_thresh, approx_sum;
    logic [15:0] op_a, op_b;
    logic [3:0]  conf_select, best_conf;
    logic        busy, done, fail;
    logic        plus1;

    int n_cmp = 0;
    int n_bad = 0;

    conf_int_add__conf_ctrl #(
        .DATA_PATH_BITWIDTH(16),
        .CONF_SELECT__C_B(4),
        .MAX_CONF(4),
        .CONF_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .err_thresh(err_thresh), .approx_sum(approx_sum),
        .op_a(op_a), .op_b(op_b), .conf_select(conf_select),
        .busy(busy), .done(done), .best_conf(best_conf), .fail(fail)
    );

    always #5 clk = ~clk;

    // Adder model: exact sum, dropped bits set to 1; optional +1 at level 0.
    always_comb begin
        logic [15:0] s;
        s = op_a + op_b;
        for (int i = 0; i < 16; i++) begin
            if (i < 4 * int'(conf_select)) s[i] = 1'b1;
        end
        if (plus1 && conf_select == 4'd0) s = op_a + op_b + 16'd1;
        approx_sum = s;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] th;
        logic        p1;
        logic [3:0]  best;
        logic        fl;
        int          cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        int cyc;
        @(negedge clk);
        a = v.a; b = v.b; err_thresh = v.th; plus1 = v.p1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); err_thresh = 16'($urandom);
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc % 2 == 1) chk("drive_conf", 32'(conf_select), 32'((cyc - 1) / 2));
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_cycle", 32'(cyc), 32'(v.cyc));
        chk("best_conf", 32'(best_conf), 32'(v.best));
        chk("fail", 32'(fail), 32'(v.fl));
        chk("op_a_held", 32'(op_a), 32'(v.a));
        chk("op_b_held", 32'(op_b), 32'(v.b));
        @(posedge clk); #1;
        chk("done_one_wide", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_conf_select", 32'(conf_select), 32'(v.best));
    endtask

    initial begin
        //              a         b         th        p1    best  fl    cyc
        vecs[0] = '{16'h1234, 16'h0011, 16'h0010, 1'b0, 4'd1, 1'b0, 7};
        vecs[1] = '{16'h1234, 16'h0011, 16'hFFFF, 1'b0, 4'd4, 1'b0, 11};
        vecs[2] = '{16'h1230, 16'h0010, 16'h0000, 1'b0, 4'd1, 1'b0, 7};
        vecs[3] = '{16'h1234, 16'h0011, 16'h0000, 1'b1, 4'd0, 1'b1, 3};
        vecs[4] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0, 4'd4, 1'b0, 11};
        vecs[5] = '{16'h00FF, 16'h0000, 16'h00FF, 1'b0, 4'd4, 1'b0, 11};
        vecs[6] = '{16'h00FF, 16'h0000, 16'h00FE, 1'b0, 4'd1, 1'b0, 7};
        vecs[7] = '{16'h1234, 16'h0011, 16'h0010, 1'b0, 4'd1, 1'b0, 7};

        rst = 1'b1; start = 1'b0; plus1 = 1'b0;
        a = '0; b = '0; err_thresh = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_best_conf", 32'(best_conf), 32'd0);
        chk("rst_conf_select", 32'(conf_select), 32'd0);
        chk("rst_op_a", 32'(op_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during the second SAMPLE (cycle 4 after accept).
        @(negedge clk);
        a = 16'h1234; b = 16'h0011; err_thresh = 16'hFFFF; plus1 = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_conf_select", 32'(conf_select), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_fail", 32'(fail), 32'd0);
        chk("arst_best_conf", 32'(best_conf), 32'd0);
        chk("arst_conf_select", 32'(conf_select), 32'd0);
        chk("arst_op_a", 32'(op_a), 32'd0);
        chk("arst_op_b", 32'(op_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0]);

        // start held high 20 edges: sweeps accepted at edges 0 and 12 only.
        for (int k = 0; k < 30; k++) begin
            int cyc;
            @(negedge clk);
            a = 16'h1234; b = 16'h0011; err_thresh = 16'hFFFF;
            start = (k < 20);
            @(posedge clk); #1;
            cyc = k + 1;
            chk("b2b_done", 32'(done), 32'((cyc == 11 || cyc == 23) ? 1 : 0));
            chk("b2b_busy", 32'(busy), 32'((cyc <= 11 || (cyc >= 13 && cyc <= 23)) ? 1 : 0));
        end
        start = 1'b0;
        chk("b2b_best_conf", 32'(best_conf), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
